// File: rtl/grid_collapse.sv
// 4x3 playfield owner: merges dropped pieces, clears full rows one at a time,
// collapses the rows above each cleared row and keeps a saturating line count.
module grid_collapse #(
    parameter int unsigned LINES_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [11:0]        piece,
    output logic [11:0]        grid,
    output logic [2:0]         row_cleared,
    output logic               collide,
    output logic               done,
    output logic [LINES_W-1:0] lines
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_SHIFT = 2'd3;

    localparam logic [LINES_W-1:0] LINES_ONE = {{(LINES_W-1){1'b0}}, 1'b1};
    localparam logic [LINES_W-1:0] LINES_MAX = {LINES_W{1'b1}};

    logic [1:0]         state_q, state_d;
    logic [11:0]        grid_q, grid_d;
    logic [1:0]         row_q, row_d;
    logic [LINES_W-1:0] lines_q, lines_d;
    logic [2:0]         row_cleared_q, row_cleared_d;
    logic               collide_q, collide_d;
    logic               done_q, done_d;
    logic [2:0]         row_full;

    assign row_full[0] = &grid_q[3:0];
    assign row_full[1] = &grid_q[7:4];
    assign row_full[2] = &grid_q[11:8];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state_q;
        grid_d        = grid_q;
        row_d         = row_q;
        lines_d       = lines_q;
        row_cleared_d = 3'b000;
        collide_d     = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if ((grid_q & piece) != 12'h000) begin
                        collide_d = 1'b1;
                    end else begin
                        grid_d  = grid_q | piece;
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                // Top row wins when several rows are full at once.
                if (row_full[0]) begin
                    row_d   = 2'd0;
                    state_d = S_CLEAR;
                end else if (row_full[1]) begin
                    row_d   = 2'd1;
                    state_d = S_CLEAR;
                end else if (row_full[2]) begin
                    row_d   = 2'd2;
                    state_d = S_CLEAR;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                case (row_q)
                    2'd0:    begin grid_d[3:0]  = 4'h0; row_cleared_d = 3'b001; end
                    2'd1:    begin grid_d[7:4]  = 4'h0; row_cleared_d = 3'b010; end
                    default: begin grid_d[11:8] = 4'h0; row_cleared_d = 3'b100; end
                endcase
                if (lines_q != LINES_MAX) begin
                    lines_d = lines_q + LINES_ONE;
                end
                state_d = S_SHIFT;
            end
            default: begin  // S_SHIFT: rows above the cleared one drop by one
                case (row_q)
                    2'd0: begin
                        grid_d[3:0] = 4'h0;
                    end
                    2'd1: begin
                        grid_d[7:4] = grid_q[3:0];
                        grid_d[3:0] = 4'h0;
                    end
                    default: begin
                        grid_d[11:8] = grid_q[7:4];
                        grid_d[7:4]  = grid_q[3:0];
                        grid_d[3:0]  = 4'h0;
                    end
                endcase
                state_d = S_CHECK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grid_q        <= 12'h000;
            row_q         <= 2'd0;
            lines_q       <= '0;
            row_cleared_q <= 3'b000;
            collide_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q       <= state_d;
            grid_q        <= grid_d;
            row_q         <= row_d;
            lines_q       <= lines_d;
            row_cleared_q <= row_cleared_d;
            collide_q     <= collide_d;
            done_q        <= done_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign grid        = grid_q;
    assign row_cleared = row_cleared_q;
    assign collide     = collide_q;
    assign done        = done_q;
    assign lines       = lines_q;

endmodule

// File: tb/tb_grid_collapse.sv
// Randomized plus directed bench for grid_collapse; a row-level playfield model
// predicts every output after each clock edge.
module tb_grid_collapse;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] piece;

    logic        in_ready, collide, done;
    logic [11:0] grid;
    logic [2:0]  row_cleared;
    logic [7:0]  lines;

    logic        in_ready_s, collide_s, done_s;
    logic [11:0] grid_s;
    logic [2:0]  row_cleared_s;
    logic [1:0]  lines_s;

    always #5 clk = ~clk;

    grid_collapse #(.LINES_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .piece(piece), .grid(grid), .row_cleared(row_cleared),
        .collide(collide), .done(done), .lines(lines)
    );

    grid_collapse #(.LINES_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .piece(piece), .grid(grid_s), .row_cleared(row_cleared_s),
        .collide(collide_s), .done(done_s), .lines(lines_s)
    );

    typedef struct packed {
        logic [11:0] grid;
        logic [2:0]  rc;
        logic        collide;
        logic        done;
        logic        ready;
        logic [7:0]  l8;
        logic [1:0]  l2;
    } snap_t;

    // Model: playfield as three 4-bit rows, a script of expected snapshots per edge.
    logic [3:0] m_row [3];
    logic [7:0] m_l8;
    logic [1:0] m_l2;
    snap_t      exp_q[$];
    snap_t      cur;
    logic       accepted;
    logic       rst_val;

    int checks = 0;
    int errors = 0;

    function automatic logic [11:0] m_grid();
        return {m_row[2], m_row[1], m_row[0]};
    endfunction

    function automatic snap_t mk_snap(input logic ready);
        snap_t s;
        s.grid = m_grid(); s.rc = 3'b000; s.collide = 1'b0; s.done = 1'b0;
        s.ready = ready; s.l8 = m_l8; s.l2 = m_l2;
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_row[k] = 4'h0;
        m_l8 = 8'd0;
        m_l2 = 2'd0;
        exp_q.delete();
        cur = mk_snap(1'b1);
    endtask

    // Expand one accepted piece into the snapshot seen after each following edge.
    task automatic build(input logic [11:0] p);
        snap_t s;
        int    r;
        if ((m_grid() & p) != 12'h000) begin
            s = mk_snap(1'b1);
            s.collide = 1'b1;
            exp_q.push_back(s);
            return;
        end
        for (int k = 0; k < 3; k++) m_row[k] = m_row[k] | p[4*k +: 4];
        exp_q.push_back(mk_snap(1'b0));
        forever begin
            r = -1;
            for (int k = 0; k < 3; k++) if (r < 0 && m_row[k] == 4'hF) r = k;
            if (r < 0) begin
                s = mk_snap(1'b1);
                s.done = 1'b1;
                exp_q.push_back(s);
                break;
            end
            exp_q.push_back(mk_snap(1'b0));
            m_row[r] = 4'h0;
            m_l8 = (m_l8 == 8'hFF) ? m_l8 : m_l8 + 8'd1;
            m_l2 = (m_l2 == 2'd3) ? m_l2 : m_l2 + 2'd1;
            s = mk_snap(1'b0);
            s.rc = 3'b001 << r;
            exp_q.push_back(s);
            for (int k = r; k > 0; k--) m_row[k] = m_row[k-1];
            m_row[0] = 4'h0;
            exp_q.push_back(mk_snap(1'b0));
        end
    endtask

    task automatic model_edge();
        accepted = 1'b0;
        if (!rst_n) return;
        if (exp_q.size() == 0 && in_valid) begin
            build(piece);
            accepted = 1'b1;
        end
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else                  cur = mk_snap(1'b1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("grid",        {20'd0, grid},        {20'd0, cur.grid});
        check("row_cleared", {29'd0, row_cleared}, {29'd0, cur.rc});
        check("collide",     {31'd0, collide},     {31'd0, cur.collide});
        check("done",        {31'd0, done},        {31'd0, cur.done});
        check("in_ready",    {31'd0, in_ready},    {31'd0, cur.ready});
        check("lines",       {24'd0, lines},       {24'd0, cur.l8});
        check("grid_s",      {20'd0, grid_s},      {20'd0, cur.grid});
        check("done_s",      {31'd0, done_s},      {31'd0, cur.done});
        check("lines_s",     {30'd0, lines_s},     {30'd0, cur.l2});
    endtask

    // One clock: drive at negedge, advance model at posedge, compare 1 time unit later.
    task automatic step(input logic v, input logic [11:0] p);
        @(negedge clk);
        rst_n    = rst_val;
        in_valid = v;
        piece    = p;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic reset_assert();
        #2;
        rst_n    = 1'b0;
        rst_val  = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset();
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    int          sat_exp [4] = '{1, 2, 3, 3};
    logic        pend;
    logic [11:0] pend_piece;
    logic [11:0] mask;

    initial begin
        rst_n = 1'b0; rst_val = 1'b0; in_valid = 1'b0; piece = 12'h000;
        model_reset();

        step(1'b0, 12'h000);
        step(1'b0, 12'h000);
        check("rst_grid",  {20'd0, grid}, 32'h0);
        check("rst_lines", {24'd0, lines}, 32'h0);
        check("rst_ready", {31'd0, in_ready}, 32'h1);
        rst_val = 1'b1;
        step(1'b0, 12'h000);

        // Plain merge: done on the second cycle counting the acceptance edge as the first.
        step(1'b1, 12'h012);
        check("t1_grid", {20'd0, grid}, 32'h012);
        check("t1_busy", {31'd0, in_ready}, 32'h0);
        step(1'b0, 12'h000);
        check("t1_done",  {31'd0, done}, 32'h1);
        check("t1_lines", {24'd0, lines}, 32'h0);

        // Overlap is rejected with a collide pulse.
        step(1'b1, 12'hFF0);
        check("t2_collide", {31'd0, collide}, 32'h1);
        check("t2_grid",    {20'd0, grid}, 32'h012);
        check("t2_ready",   {31'd0, in_ready}, 32'h1);
        step(1'b0, 12'h000);
        check("t2_no_done", {31'd0, done}, 32'h0);

        // Two rows completed; in_valid held high while busy must be ignored.
        step(1'b1, 12'hFE0);
        check("t3_merge", {20'd0, grid}, 32'hFF2);
        step(1'b1, 12'h00F);
        step(1'b1, 12'h00F);
        check("t3_rc_mid",  {29'd0, row_cleared}, 32'b010);
        check("t3_clr_mid", {20'd0, grid}, 32'hF02);
        step(1'b1, 12'h00F);
        check("t3_shift1", {20'd0, grid}, 32'hF20);
        step(1'b1, 12'h00F);
        step(1'b1, 12'h00F);
        check("t3_rc_bot",  {29'd0, row_cleared}, 32'b100);
        check("t3_clr_bot", {20'd0, grid}, 32'h020);
        step(1'b1, 12'h00F);
        check("t3_shift2", {20'd0, grid}, 32'h200);
        step(1'b1, 12'h00F);
        check("t3_done",  {31'd0, done}, 32'h1);
        check("t3_lines", {24'd0, lines}, 32'd2);
        step(1'b0, 12'h000);

        // Bottom row then top row from an empty field.
        reset_assert();
        rst_val = 1'b1;
        step(1'b0, 12'h000);
        step(1'b1, 12'hF00);
        step(1'b0, 12'h000);
        step(1'b0, 12'h000);
        check("t4_rc",    {29'd0, row_cleared}, 32'b100);
        check("t4_grid",  {20'd0, grid}, 32'h000);
        check("t4_lines", {24'd0, lines}, 32'd1);
        step(1'b0, 12'h000);
        step(1'b0, 12'h000);
        check("t4_done", {31'd0, done}, 32'h1);
        step(1'b1, 12'h00F);
        step(1'b0, 12'h000);
        step(1'b0, 12'h000);
        check("t4_rc_top", {29'd0, row_cleared}, 32'b001);
        check("t4_lines2", {24'd0, lines}, 32'd2);
        step(1'b0, 12'h000);
        step(1'b0, 12'h000);

        // Reset during SHIFT of a two-row clear abandons it without done.
        step(1'b1, 12'hFF0);
        step(1'b0, 12'h000);
        step(1'b0, 12'h000);
        reset_assert();
        check("t5_grid",  {20'd0, grid}, 32'h0);
        check("t5_lines", {24'd0, lines}, 32'h0);
        check("t5_rc",    {29'd0, row_cleared}, 32'h0);
        step(1'b0, 12'h000);
        step(1'b0, 12'h000);
        rst_val = 1'b1;
        step(1'b0, 12'h000);
        check("t5_ready", {31'd0, in_ready}, 32'h1);
        repeat (4) step(1'b0, 12'h000);

        // Narrow counter saturates.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 12'h00F);
            repeat (4) step(1'b1, 12'h00F);
            check("t6_lines_s", {30'd0, lines_s}, sat_exp[i]);
            step(1'b0, 12'h000);
        end

        // Random traffic with occasional asynchronous resets.
        pend = 1'b0;
        pend_piece = 12'h000;
        for (int c = 0; c < 4000; c++) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                pend = 1'b1;
                case ($urandom_range(0, 3))
                    0: pend_piece = 12'($urandom);
                    1: pend_piece = ~m_grid() & 12'($urandom);
                    2: begin
                        mask = 12'h00F;
                        mask = mask << (4 * $urandom_range(0, 2));
                        pend_piece = ~m_grid() & mask;
                    end
                    default: pend_piece = ~m_grid() & 12'($urandom | $urandom);
                endcase
            end
            step(pend, pend_piece);
            if (accepted) pend = 1'b0;
            if ($urandom_range(0, 399) == 0) begin
                reset_assert();
                pend = 1'b0;
                step(1'b0, 12'h000);
                rst_val = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_collapse.md
Name: grid_collapse

Overview:
- Owns the 4x3 playfield register (12 bits) and is the consumer of full-row detection.
- Accepts dropped piece masks over a valid/ready handshake and merges them into the grid.
- Clears every fully occupied row and collapses the rows above it downward, then reports completion and a running cleared-line count.
- Sits between the piece-drop logic upstream and the display/score logic downstream.

Parameters:
- LINES_W, 8, width of the cleared-line counter; the counter saturates at 2^LINES_W-1.

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  piece mask on piece is valid.
- in_ready  output  1  block can accept a piece; high only in IDLE.
- piece  input  12  piece occupancy mask. Same layout as grid.
- grid  output  12  registered playfield. Row layout:
  - row0 (top) = [3:0]
  - row1 (mid) = [7:4]
  - row2 (bottom) = [11:8]
- row_cleared  output  3  one-hot, registered; pulses 1 cycle after a CLEAR state. Bit k = row k was cleared.
- collide  output  1  registered 1-cycle pulse; piece rejected because it overlaps the grid.
- done  output  1  registered 1-cycle pulse; an accepted piece has been fully resolved.
- lines  output  LINES_W  total rows cleared since reset; saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, grid=0, lines=0, row_cleared=0, collide=0, done=0. This applies mid-operation too: any in-flight collapse is abandoned and no done pulse is produced.
- States: IDLE, CHECK, CLEAR, SHIFT. in_ready = (state==IDLE).
- Pulse outputs (collide, done, row_cleared) default to 0 every cycle unless set below.
- IDLE:
  - Acceptance is in_valid & in_ready at a rising edge.
  - If (grid & piece) != 0: grid unchanged, collide=1 next cycle, stay IDLE.
  - Otherwise: grid <= grid | piece, go to CHECK.
  - piece=0 is legal: it merges nothing and still proceeds through CHECK to done.
- CHECK (1 cycle): find the full row (all 4 bits set), priority top > mid > bottom.
  - None full: done=1 next cycle, go to IDLE.
  - Otherwise: latch r = that row index, go to CLEAR.
- CLEAR (1 cycle):
  - row r of grid <= 0.
  - row_cleared <= one-hot(r).
  - lines <= lines+1, holding at 2^LINES_W-1 when already there.
  - Go to SHIFT.
- SHIFT (1 cycle):
  - For every k < r, row k+1 <= row k. Row0 <= 0. Rows with index > r are unchanged.
  - r=0 therefore only re-zeroes row0.
  - Go to CHECK.
- Repeats until CHECK finds no full row; at most 3 rows are cleared per piece.
- Latency from the acceptance edge to done high:
  - 2 cycles with no clears.
  - Plus 3 cycles per cleared row.
- in_valid while busy (in_ready=0) is ignored. The sender holds piece and in_valid until acceptance.
- A piece may complete several rows; each is cleared in its own CLEAR/SHIFT pass, re-evaluated after each shift.

Test Plan:
- Reset, then place piece=12'h012 → accepted, grid=12'h012, done pulses 2 cycles after acceptance, lines=0, row_cleared never nonzero.
- With grid=12'h012, place 12'hFF0 → collide pulses 1 cycle after the edge, grid stays 12'h012, in_ready stays 1, no done.
- With grid=12'h012, place 12'hFE0 → intermediate grid 12'hFF2, then:
  - row_cleared=3'b010 with grid 12'hF02, then grid 12'hF20 after SHIFT.
  - row_cleared=3'b100, then final grid=12'h200.
  - lines=2; done 8 cycles after acceptance.
- From reset, place 12'hF00 → bottom cleared, row_cleared=3'b100, grid=0, lines=1, done 5 cycles after acceptance. Then place 12'h00F → row_cleared=3'b001, grid=0, lines=2.
- Assert rst_n=0 asynchronously during SHIFT of a multi-row clear → grid, lines, and all pulses are 0 immediately; state is IDLE (in_ready=1) after rst_n returns high; no done is produced.
- With LINES_W=2, clear 4 single rows → lines reads 1, 2, 3, 3 (saturates). Holding in_valid=1 while busy produces no extra acceptances.
